// File: rtl/cnu_minsum_stream_if.sv
// Beat-in / row-result-out bundle for the streaming check-node min-finder.
// The master drives beats and observes results; the slave is the CNU block.
interface cnu_minsum_stream_if #(
    parameter int data_w = 8,
    parameter int idx_w  = 8,
    parameter int P      = 4
);
    logic                  in_valid;
    logic                  in_first;
    logic                  in_last;
    logic [P-1:0]          in_mask;
    logic [data_w*P-1:0]   in_mag;
    logic [P-1:0]          in_sign;

    logic                  out_valid;
    logic [data_w-1:0]     out_min;
    logic [data_w-1:0]     out_min2;
    logic [idx_w-1:0]      out_idx;
    logic                  out_sign;
    logic [idx_w-1:0]      out_deg;
    logic                  err_proto;

    modport master (
        output in_valid, in_first, in_last, in_mask, in_mag, in_sign,
        input  out_valid, out_min, out_min2, out_idx, out_sign, out_deg, err_proto
    );

    modport slave (
        input  in_valid, in_first, in_last, in_mask, in_mag, in_sign,
        output out_valid, out_min, out_min2, out_idx, out_sign, out_deg, err_proto
    );
endinterface

// File: rtl/cnu_minsum_stream.sv
// Variable-degree min-sum check node: reduces one P-lane beat per cycle, merges
// beats into a row accumulator, and emits offset-corrected row results.
module cnu_minsum_stream #(
    parameter int data_w = 8,
    parameter int idx_w  = 8,
    parameter int P      = 4,
    parameter int OFFSET = 0
) (
    input  logic                clk,
    input  logic                rst,
    cnu_minsum_stream_if.slave  bus
);
    localparam logic [0:0]        ST_IDLE  = 1'b0;
    localparam logic [0:0]        ST_ROW   = 1'b1;
    localparam logic [data_w-1:0] MAG_ONES = '1;
    localparam logic [data_w-1:0] OFS      = data_w'(OFFSET);

    // Row framing
    logic [0:0]        state_q, state_d;
    logic [idx_w-1:0]  beat_cnt_q, beat_cnt_d;
    logic              accept;
    logic              proto_err;
    logic [idx_w-1:0]  beat_base;

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        accept     = 1'b0;
        proto_err  = 1'b0;
        beat_base  = '0;
        if (bus.in_valid) begin
            if (bus.in_first) begin
                accept     = 1'b1;
                proto_err  = (state_q == ST_ROW);
                beat_cnt_d = idx_w'(1);
                state_d    = bus.in_last ? ST_IDLE : ST_ROW;
            end else if (state_q == ST_ROW) begin
                accept     = 1'b1;
                beat_base  = beat_cnt_q * idx_w'(P);
                beat_cnt_d = beat_cnt_q + idx_w'(1);
                if (bus.in_last) begin
                    state_d = ST_IDLE;
                end
            end else begin
                proto_err = 1'b1;
            end
        end
    end

    // Stage 1: beat reduction. Masked lanes behave as all-ones magnitude.
    logic [data_w-1:0] lane_mag;
    logic [data_w-1:0] bt_min, bt_min2;
    logic [idx_w-1:0]  bt_idx;
    logic              bt_sign;
    logic [idx_w-1:0]  bt_cnt;

    always_comb begin
        lane_mag = '0;
        bt_min   = MAG_ONES;
        bt_min2  = MAG_ONES;
        bt_idx   = '0;
        bt_sign  = 1'b0;
        bt_cnt   = '0;
        for (int k = 0; k < P; k++) begin
            if (bus.in_mask[k]) begin
                lane_mag = bus.in_mag[k*data_w +: data_w];
                bt_sign  = bt_sign ^ bus.in_sign[k];
                bt_cnt   = bt_cnt + idx_w'(1);
                // Strict less-than keeps the lower index on ties.
                if (lane_mag < bt_min) begin
                    bt_min2 = bt_min;
                    bt_min  = lane_mag;
                    bt_idx  = beat_base + idx_w'(k);
                end else if (lane_mag < bt_min2) begin
                    bt_min2 = lane_mag;
                end
            end
        end
    end

    logic              s1_valid_q, s1_first_q, s1_last_q, s1_err_q;
    logic [data_w-1:0] s1_min_q, s1_min2_q;
    logic [idx_w-1:0]  s1_idx_q, s1_cnt_q;
    logic              s1_sign_q;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_min_q   <= '0;
            s1_min2_q  <= '0;
            s1_idx_q   <= '0;
            s1_cnt_q   <= '0;
            s1_sign_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            s1_valid_q <= accept;
            s1_first_q <= bus.in_first;
            s1_last_q  <= bus.in_last;
            s1_err_q   <= proto_err;
            s1_min_q   <= bt_min;
            s1_min2_q  <= bt_min2;
            s1_idx_q   <= bt_idx;
            s1_cnt_q   <= bt_cnt;
            s1_sign_q  <= bt_sign;
        end
    end

    // Stage 2: row accumulation
    logic [data_w-1:0] acc_min_q, acc_min_d, acc_min2_q, acc_min2_d;
    logic [idx_w-1:0]  acc_idx_q, acc_idx_d, acc_deg_q, acc_deg_d;
    logic              acc_sign_q, acc_sign_d;
    logic              emit_q, emit_d;
    logic [data_w-1:0] loser_min;

    always_comb begin
        acc_min_d  = acc_min_q;
        acc_min2_d = acc_min2_q;
        acc_idx_d  = acc_idx_q;
        acc_deg_d  = acc_deg_q;
        acc_sign_d = acc_sign_q;
        emit_d     = 1'b0;
        loser_min  = MAG_ONES;
        if (s1_valid_q) begin
            if (s1_first_q) begin
                acc_min_d  = s1_min_q;
                acc_min2_d = s1_min2_q;
                acc_idx_d  = s1_idx_q;
                acc_deg_d  = s1_cnt_q;
                acc_sign_d = s1_sign_q;
            end else begin
                // The accumulator holds lower indices, so it wins ties.
                if (s1_min_q < acc_min_q) begin
                    acc_min_d = s1_min_q;
                    acc_idx_d = s1_idx_q;
                    loser_min = acc_min_q;
                end else begin
                    loser_min = s1_min_q;
                end
                acc_min2_d = loser_min;
                if (acc_min2_q < acc_min2_d) acc_min2_d = acc_min2_q;
                if (s1_min2_q < acc_min2_d)  acc_min2_d = s1_min2_q;
                acc_deg_d  = acc_deg_q + s1_cnt_q;
                acc_sign_d = acc_sign_q ^ s1_sign_q;
            end
            emit_d = s1_last_q;
        end
    end

    // Output correction: saturating offset; degree<2 leaves min2 as all-ones.
    logic [data_w-1:0] out_min_d, out_min2_d;

    always_comb begin
        out_min_d  = (acc_min_q > OFS) ? acc_min_q - OFS : '0;
        out_min2_d = (acc_min2_q > OFS) ? acc_min2_q - OFS : '0;
        if (acc_deg_q == '0) begin
            out_min_d = MAG_ONES;
        end
        if (acc_deg_q < idx_w'(2)) begin
            out_min2_d = MAG_ONES;
        end
    end

    logic              out_valid_q, out_sign_q, err_proto_q;
    logic [data_w-1:0] out_min_q, out_min2_q;
    logic [idx_w-1:0]  out_idx_q, out_deg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_min_q   <= '0;
            acc_min2_q  <= '0;
            acc_idx_q   <= '0;
            acc_deg_q   <= '0;
            acc_sign_q  <= 1'b0;
            emit_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_min_q   <= '0;
            out_min2_q  <= '0;
            out_idx_q   <= '0;
            out_sign_q  <= 1'b0;
            out_deg_q   <= '0;
            err_proto_q <= 1'b0;
        end else begin
            acc_min_q   <= acc_min_d;
            acc_min2_q  <= acc_min2_d;
            acc_idx_q   <= acc_idx_d;
            acc_deg_q   <= acc_deg_d;
            acc_sign_q  <= acc_sign_d;
            emit_q      <= emit_d;
            out_valid_q <= emit_q;
            err_proto_q <= s1_err_q;
            if (emit_q) begin
                out_min_q  <= out_min_d;
                out_min2_q <= out_min2_d;
                out_idx_q  <= (acc_deg_q == '0) ? '0 : acc_idx_q;
                out_sign_q <= acc_sign_q;
                out_deg_q  <= acc_deg_q;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_min   = out_min_q;
    assign bus.out_min2  = out_min2_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_sign  = out_sign_q;
    assign bus.out_deg   = out_deg_q;
    assign bus.err_proto = err_proto_q;
endmodule

// File: tb/tb_cnu_minsum_stream.sv
// Scoreboard bench for cnu_minsum_stream: directed rows plus random rows,
// checked against a list-based row model with OFFSET=2.
module tb_cnu_minsum_stream;
    localparam int DW  = 8;
    localparam int IW  = 8;
    localparam int P   = 4;
    localparam int OFS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cnu_minsum_stream_if #(.data_w(DW), .idx_w(IW), .P(P)) bus ();

    cnu_minsum_stream #(.data_w(DW), .idx_w(IW), .P(P), .OFFSET(OFS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int mn;
        int mn2;
        int idx;
        int sgn;
        int deg;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   err_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Row model: enabled lanes kept as plain lists of magnitudes and global indices.
    bit in_row = 0;
    int beat_no = 0;
    int row_mag[$];
    int row_idx[$];
    int row_sgn = 0;

    function automatic int sat(input int v);
        return (v > OFS) ? v - OFS : 0;
    endfunction

    function automatic exp_t model_row(input int c);
        exp_t e;
        int best = -1;
        int second = 255;
        e.deg = row_mag.size();
        e.sgn = row_sgn;
        e.cyc = c;
        foreach (row_mag[i]) if (best < 0 || row_mag[i] < row_mag[best]) best = i;
        foreach (row_mag[i]) if (i != best && row_mag[i] < second) second = row_mag[i];
        e.mn  = (e.deg == 0) ? 255 : sat(row_mag[best]);
        e.idx = (e.deg == 0) ? 0 : row_idx[best];
        e.mn2 = (e.deg < 2) ? 255 : sat(second);
        return e;
    endfunction

    function automatic logic [DW*P-1:0] pack(input int a, input int b, input int c, input int d);
        return {DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    task automatic send(input bit first, input bit last, input logic [P-1:0] mask,
                        input logic [DW*P-1:0] mags, input logic [P-1:0] signs);
        bit take;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_first = first;
        bus.in_last  = last;
        bus.in_mask  = mask;
        bus.in_mag   = mags;
        bus.in_sign  = signs;
        take = 0;
        if (first) begin
            if (in_row) err_q.push_back(cyc + 2);
            row_mag.delete();
            row_idx.delete();
            row_sgn = 0;
            beat_no = 0;
            take = 1;
        end else if (in_row) begin
            take = 1;
        end else begin
            err_q.push_back(cyc + 2);
        end
        if (take) begin
            for (int k = 0; k < P; k++) begin
                if (mask[k]) begin
                    row_mag.push_back(int'(mags[k*DW +: DW]));
                    row_idx.push_back((beat_no * P + k) % 256);
                    row_sgn ^= int'(signs[k]);
                end
            end
            beat_no++;
            in_row = !last;
            if (last) exp_q.push_back(model_row(cyc + 3));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            bus.in_first = 1'b0;
            bus.in_last  = 1'b0;
        end
    endtask

    function automatic logic [DW*P-1:0] rand_mags();
        logic [DW*P-1:0] m;
        for (int k = 0; k < P; k++) m[k*DW +: DW] = DW'($urandom_range(0, 254));
        return m;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a result or an error.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_cycle", cyc, e.cyc);
                    check("out_min",   bus.out_min,  e.mn);
                    check("out_min2",  bus.out_min2, e.mn2);
                    check("out_idx",   bus.out_idx,  e.idx);
                    check("out_sign",  bus.out_sign, e.sgn);
                    check("out_deg",   bus.out_deg,  e.deg);
                end
            end
            if (bus.err_proto) begin
                if (err_q.size() == 0) check("spurious_err_proto", 1, 0);
                else check("err_cycle", cyc, err_q.pop_front());
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_min"},   bus.out_min,   0);
        check({tag, "_out_min2"},  bus.out_min2,  0);
        check({tag, "_out_idx"},   bus.out_idx,   0);
        check({tag, "_out_sign"},  bus.out_sign,  0);
        check({tag, "_out_deg"},   bus.out_deg,   0);
        check({tag, "_err_proto"}, bus.err_proto, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_mask  = '0;
        bus.in_mag   = '0;
        bus.in_sign  = '0;
        repeat (3) @(posedge clk);
        #2;
        check_zero_outputs("reset");
        rst = 1'b0;
        idle(2);

        // Single beat with a tie for the minimum
        send(1, 1, 4'hF, pack(9, 3, 7, 3), 4'b1101);
        idle(1);
        // Three beats with a bubble; global min at beat 2 lane 2
        send(1, 0, 4'hF, pack(8, 5, 9, 12), 4'b0110);
        idle(1);
        send(0, 0, 4'hF, pack(7, 6, 20, 5), 4'b0001);
        send(0, 1, 4'hF, pack(9, 11, 1, 30), 4'b1000);
        idle(1);
        // Offset saturation, degree 1 and degree 0 rows
        send(1, 1, 4'b0011, pack(1, 4, 200, 100), 4'b0000);
        send(1, 1, 4'b0001, pack(6, 0, 0, 0), 4'b0001);
        send(1, 1, 4'b0000, pack(1, 2, 3, 4), 4'b1111);
        idle(1);
        // Three back-to-back single-beat rows
        send(1, 1, 4'hF, pack(10, 20, 30, 40), 4'b0001);
        send(1, 1, 4'hA, pack(0, 50, 3, 17), 4'b1010);
        send(1, 1, 4'h7, pack(4, 4, 4, 4), 4'b0111);
        idle(2);
        // Restart mid-row, then a lone beat in IDLE
        send(1, 0, 4'hF, pack(0, 0, 0, 0), 4'b0000);
        send(1, 0, 4'hF, pack(13, 14, 15, 16), 4'b0011);
        send(0, 1, 4'hF, pack(12, 2, 90, 3), 4'b0100);
        idle(1);
        send(0, 1, 4'hF, pack(1, 1, 1, 1), 4'b1111);
        idle(5);

        // Reset in the middle of a row
        send(1, 0, 4'hF, pack(1, 2, 3, 4), 4'b0000);
        idle(1);
        #2 rst = 1'b1;
        in_row = 0;
        #3;
        check_zero_outputs("midrow_reset");
        @(posedge clk); #2 rst = 1'b0;
        idle(4);
        check("post_reset_out_valid", bus.out_valid, 0);
        send(1, 0, 4'hF, pack(40, 30, 20, 10), 4'b1111);
        send(0, 1, 4'h3, pack(25, 9, 0, 0), 4'b0010);
        idle(1);

        // Random rows with bubbles, restarts and stray beats
        for (int r = 0; r < 80; r++) begin
            int  nb;
            bit  cut;
            nb  = $urandom_range(1, 4);
            cut = (nb > 1) && ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 11) == 0) send(0, $urandom_range(0, 1), 4'hF, rand_mags(), 4'hF);
            for (int b = 0; b < nb; b++) begin
                logic [P-1:0] m;
                m = ($urandom_range(0, 5) == 0) ? P'($urandom) : 4'hF;
                if (cut && b == nb - 1) break;
                send(b == 0, b == nb - 1, m, rand_mags(), P'($urandom));
                if ($urandom_range(0, 3) == 0) idle(1);
            end
        end
        idle(8);

        check("exp_queue_drained", exp_q.size(), 0);
        check("err_queue_drained", err_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
